// File: rtl/axi_resp_mem.sv
// AXI4-Lite slave responder with a word-addressed backing register memory.
// Independent write and read channels; decode errors and fixed read wait states.
module axi_resp_mem #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned RD_WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned IW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(RD_WAIT);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {
        W_ACC,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rstate_e;

    logic [31:0] mem_q [DEPTH];

    wstate_e     wstate_q;
    logic        aw_held_q;
    logic        w_held_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    rstate_e     rstate_q;
    logic        arready_q;
    logic [31:0] araddr_q;
    logic [3:0]  cnt_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic          aw_fire;
    logic          w_fire;
    logic          aw_have;
    logic          w_have;
    logic          commit;
    logic [31:0]   w_addr;
    logic [31:0]   w_dat;
    logic [3:0]    w_stb;
    logic [31:0]   w_off;
    logic [1:0]    w_resp;
    logic [IW-1:0] w_idx;

    logic          ar_fire;
    logic [31:0]   r_off;
    logic [1:0]    r_resp;
    logic [IW-1:0] r_idx;

    // A channel's payload comes from its holding register once accepted,
    // otherwise straight from the bus on the handshake edge.
    always_comb begin
        aw_fire = awvalid && awready_q;
        w_fire  = wvalid && wready_q;
        aw_have = aw_held_q || aw_fire;
        w_have  = w_held_q || w_fire;
        w_addr  = aw_held_q ? awaddr_q : awaddr;
        w_dat   = w_held_q ? wdata_q : wdata;
        w_stb   = w_held_q ? wstrb_q : wstrb;
        commit  = (wstate_q == W_ACC) && aw_have && w_have;
        w_off   = w_addr - BASE_ADDR;
        w_idx   = w_off[IW+1:2];
        if (w_off >= SPAN) begin
            w_resp = RESP_DECERR;
        end else if (w_addr[1:0] != 2'b00) begin
            w_resp = RESP_SLVERR;
        end else begin
            w_resp = RESP_OKAY;
        end
    end

    always_comb begin
        ar_fire = arvalid && arready_q;
        r_off   = araddr_q - BASE_ADDR;
        r_idx   = r_off[IW+1:2];
        if (r_off >= SPAN) begin
            r_resp = RESP_DECERR;
        end else if (araddr_q[1:0] != 2'b00) begin
            r_resp = RESP_SLVERR;
        end else begin
            r_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && (w_resp == RESP_OKAY)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_stb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_ACC;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (wstate_q)
                W_ACC: begin
                    if (aw_fire) begin
                        awaddr_q <= awaddr;
                    end
                    if (w_fire) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if (commit) begin
                        aw_held_q <= 1'b1;
                        w_held_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_resp;
                        wstate_q  <= W_RESP;
                    end else begin
                        aw_held_q <= aw_have;
                        w_held_q  <= w_have;
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_ACC;
                    end
                end
                default: wstate_q <= W_ACC;
            endcase
        end
    end

    // Data is captured on the first R_DATA cycle, RD_WAIT+1 edges after AR;
    // a write committing on that same edge is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            araddr_q  <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        araddr_q  <= araddr;
                        cnt_q     <= WAIT_INIT;
                        arready_q <= 1'b0;
                        rstate_q  <= (WAIT_INIT == 4'd0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= r_resp;
                        rdata_q  <= (r_resp == RESP_OKAY) ? mem_q[r_idx] : '0;
                    end else if (rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_resp_mem.sv
// Directed scoreboard bench for axi_resp_mem (DEPTH=256, BASE=0, RD_WAIT=2).
module tb_axi_resp_mem;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0]  bq [$];
    rexp_t       rq [$];
    logic [31:0] mdl [256];
    int checks;
    int failures;
    logic [31:0] got;

    axi_resp_mem #(
        .DEPTH(256),
        .BASE_ADDR(32'h0),
        .RD_WAIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .awaddr(awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp),
        .bvalid(bvalid),
        .bready(bready),
        .araddr(araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rresp(rresp),
        .rvalid(rvalid),
        .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] eresp(input logic [31:0] a);
        if (a >= 32'h400) return 2'd3;
        if (a[1:0] != 2'b00) return 2'd2;
        return 2'd0;
    endfunction

    task automatic clear_mdl();
        for (int i = 0; i < 256; i++) mdl[i] = '0;
    endtask

    task automatic exp_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        logic [7:0] ix;
        r = eresp(a);
        bq.push_back(r);
        ix = a[9:2];
        if (r == 2'd0) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[ix][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n;
        n = 0;
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_hs", {31'b0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        chk("w_hs", {31'b0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        chk("aww_hs", {30'b0, awready, wready}, 32'd3);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n;
        n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_hs", {31'b0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input int hold);
        int n;
        logic [1:0] e;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_blat"}, n, 0);
        e = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        chk({tag, "_bresp"}, {30'b0, bresp}, {30'b0, e});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_bhold"}, {29'b0, bvalid, bresp}, {29'b0, 1'b1, e});
            chk({tag, "_awr_hold"}, {31'b0, awready}, 32'd0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk({tag, "_bdrop"}, {31'b0, bvalid}, 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input int hold, output logic [31:0] o);
        int n;
        rexp_t e;
        logic [1:0] r;
        logic [7:0] ix;
        r = eresp(a);
        ix = a[9:2];
        rq.push_back('{d: (r == 2'd0) ? mdl[ix] : 32'h0, r: r});
        send_ar(a);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_rlat"}, n, 3);
        e = (rq.size() > 0) ? rq.pop_front() : 'x;
        chk({tag, "_rdata"}, rdata, e.d);
        chk({tag, "_rresp"}, {30'b0, rresp}, {30'b0, e.r});
        o = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_rvhold"}, {31'b0, rvalid}, 32'd1);
            chk({tag, "_rdhold"}, rdata, e.d);
            chk({tag, "_arr_hold"}, {31'b0, arready}, 32'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({tag, "_arready_back"}, {30'b0, arready, rvalid}, 32'd2);
    endtask

    initial begin
        bit seen_r;
        bit seen_b;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arvalid = 1'b0;
        rready = 1'b0;
        clear_mdl();

        repeat (3) @(negedge clk);
        chk("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
        chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
        chk("rst_resps", {28'b0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_readies", {29'b0, awready, wready, arready}, 32'd7);

        exp_w(32'h10, 32'hDEADBEEF, 4'hF);
        send_aw_w(32'h10, 32'hDEADBEEF, 4'hF);
        wait_b("t2", 0);
        do_read("t2", 32'h10, 0, got);
        chk("t2_const", got, 32'hDEADBEEF);

        exp_w(32'h10, 32'hA5A5A5A5, 4'b0101);
        send_w(32'hA5A5A5A5, 4'b0101);
        chk("t3_w_held", {30'b0, awready, wready}, 32'd2);
        @(negedge clk);
        send_aw(32'h10);
        wait_b("t3", 0);
        do_read("t3", 32'h10, 0, got);
        chk("t3_const", got, 32'hDEA5BEA5);

        exp_w(32'h44, 32'h11223344, 4'hF);
        send_aw(32'h44);
        chk("aw_first_held", {30'b0, awready, wready}, 32'd1);
        repeat (2) @(negedge clk);
        send_w(32'h11223344, 4'hF);
        wait_b("awfirst", 0);
        do_read("awfirst", 32'h44, 0, got);

        exp_w(32'h10, 32'hFFFFFFFF, 4'h0);
        send_aw_w(32'h10, 32'hFFFFFFFF, 4'h0);
        wait_b("strb0", 0);
        do_read("strb0", 32'h10, 0, got);
        chk("strb0_const", got, 32'hDEA5BEA5);

        exp_w(32'h400, 32'h55555555, 4'hF);
        send_aw_w(32'h400, 32'h55555555, 4'hF);
        wait_b("decerr", 0);
        do_read("decerr_w0", 32'h0, 0, got);
        chk("decerr_w0_const", got, 32'h0);
        do_read("decerr_rd", 32'h400, 0, got);
        exp_w(32'h12, 32'h77777777, 4'hF);
        send_aw_w(32'h12, 32'h77777777, 4'hF);
        wait_b("slverr_w", 0);
        do_read("slverr_chk", 32'h10, 0, got);
        do_read("slverr_rd", 32'h13, 0, got);
        chk("slverr_rresp", {30'b0, rresp}, 32'd2);
        chk("slverr_rdata", got, 32'h0);

        exp_w(32'h20, 32'hCAFEF00D, 4'hF);
        send_aw_w(32'h20, 32'hCAFEF00D, 4'hF);
        wait_b("bhold", 5);
        do_read("rhold", 32'h20, 5, got);

        send_aw(32'h30);
        send_ar(32'h10);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mdl();
        seen_r = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_r |= rvalid;
            seen_b |= bvalid;
        end
        chk("midrst_rvalid", {31'b0, seen_r}, 32'd0);
        chk("midrst_bvalid", {31'b0, seen_b}, 32'd0);
        chk("midrst_readies", {29'b0, awready, wready, arready}, 32'd7);
        do_read("midrst_30", 32'h30, 0, got);
        chk("midrst_30_const", got, 32'h0);
        do_read("midrst_10", 32'h10, 0, got);
        chk("midrst_10_const", got, 32'h0);

        chk("sb_empty", bq.size() + rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
